// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - in-order instruction fetch unit with response FIFO and redirect handling
// Issues word requests, buffers in-order responses, drops stale responses after a redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_error,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [1:0]  instr_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_ACCESS   = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_after;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          halted;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [1:0]  mem_fault [DEPTH];

  logic [CW:0] occupancy;
  logic        req_fire;
  logic        rsp_fire;
  logic        push;
  logic        pop;
  logic        misaligned;

  // Occupancy counts words requested but not yet returned plus words buffered,
  // so a full FIFO can never be overrun by returning responses.
  always_comb begin
    occupancy      = {1'b0, outstanding} + {1'b0, count};
    imem_req_valid = !rst && !halted && !redirect_valid && (occupancy < DEPTH_W);
  end

  assign imem_req_addr     = fetch_pc;
  assign req_fire          = imem_req_valid && imem_req_ready;
  assign rsp_fire          = imem_rsp_valid && (outstanding != '0);
  assign push              = rsp_fire && (drop_cnt == '0);
  assign instr_valid       = (count != '0);
  assign pop               = instr_valid && instr_ready;
  assign misaligned        = (redirect_pc[1:0] != 2'b00);
  assign outstanding_after = outstanding - CW'(rsp_fire);

  assign instr       = mem_instr[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
  assign instr_fault = mem_fault[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old stream; a response
      // arriving this cycle is already excluded from outstanding_after.
      fetch_pc    <= redirect_pc;
      rsp_pc      <= redirect_pc;
      outstanding <= outstanding_after;
      drop_cnt    <= outstanding_after;
      halted      <= misaligned;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding_after + CW'(req_fire);
      if (rsp_fire && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (push) begin
        rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_error) begin
          halted <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
        mem_fault[i] <= FAULT_NONE;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      if (misaligned) begin
        // The fault entry replaces the flushed contents so it is visible next cycle.
        mem_instr[0] <= '0;
        mem_pc[0]    <= redirect_pc;
        mem_fault[0] <= FAULT_MISALIGN;
        wr_ptr       <= PW'(1);
        count        <= CW'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_rsp_error ? 32'h0 : imem_rsp_data;
        mem_pc[wr_ptr]    <= rsp_pc;
        mem_fault[wr_ptr] <= imem_rsp_error ? FAULT_ACCESS : FAULT_NONE;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
// Directed vector table, hand sequences and random traffic against a queue-based reference model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_error;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [1:0]  instr_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_error(imem_rsp_error),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_fault(instr_fault), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rspv;
    logic [31:0] data;
    logic        err;
    logic        irdy;
    logic        redv;
    logic [31:0] redpc;
    logic        e_reqv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [1:0]  e_fault;
    logic [31:0] e_instr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rspv, input logic [31:0] data,
                              input logic err, input logic irdy, input logic redv,
                              input logic [31:0] redpc, input logic e_reqv, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_pc, input logic [1:0] e_fault,
                              input logic [31:0] e_instr);
    vec_t v;
    v = '{rdy, rspv, data, err, irdy, redv, redpc, e_reqv, e_addr, e_iv, e_pc, e_fault, e_instr};
    return v;
  endfunction

  // Reference model: queues of buffered entries and of in-flight requests, each
  // request remembering its own address and whether a redirect made it stale.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  fault;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } fl_t;

  ent_t        m_fifo[$];
  fl_t         m_fl[$];
  logic [31:0] m_fetch;
  bit          m_halt;
  logic [31:0] bus_q[$];

  int ready_pct = 100;
  int rsp_pct   = 100;
  int err_pct   = 0;
  int err_at    = -1;
  int rsp_num   = 0;
  int n_acc     = 0;
  bit stray     = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h13;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_fl.delete();
    bus_q.delete();
    m_fetch = RESET_PC;
    m_halt  = 0;
    rsp_num = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk({tag, "_instr_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_instr_fault"}, instr_fault, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit irdy, input bit redv, input logic [31:0] redpc);
    bit   m_reqv, acc, rsp, pop;
    fl_t  f;
    ent_t e;
    @(negedge clk);
    if (stray) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      imem_rsp_error = 1'b0;
    end else if (bus_q.size() > 0 && $urandom_range(99) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(bus_q.pop_front());
      imem_rsp_error = (rsp_num == err_at) || ($urandom_range(99) < err_pct);
      rsp_num++;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      imem_rsp_error = 1'($urandom_range(1));
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    instr_ready    = irdy;
    redirect_valid = redv;
    redirect_pc    = redpc;
    #1;
    m_reqv = !m_halt && !redv && (m_fl.size() + m_fifo.size() < DEPTH);
    chk("req_valid", imem_req_valid, m_reqv);
    chk("req_addr", imem_req_addr, m_fetch);
    chk("instr_valid", instr_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("instr", instr, m_fifo[0].instr);
      chk("instr_pc", instr_pc, m_fifo[0].pc);
      chk("instr_fault", instr_fault, m_fifo[0].fault);
    end
    if (imem_req_valid && imem_req_ready) begin
      bus_q.push_back(imem_req_addr);
      n_acc++;
    end
    acc = m_reqv && imem_req_ready;
    rsp = imem_rsp_valid && (m_fl.size() > 0);
    pop = (m_fifo.size() > 0) && irdy;
    if (redv) begin
      if (rsp) m_fl.delete(0);
      foreach (m_fl[i]) m_fl[i].stale = 1;
      m_fifo.delete();
      m_fetch = redpc;
      m_halt  = 0;
      if (redpc[1:0] != 2'b00) begin
        e = '{32'h0, redpc, 2'b10};
        m_fifo.push_back(e);
        m_halt = 1;
      end
    end else begin
      if (pop) m_fifo.delete(0);
      if (rsp) begin
        f = m_fl.pop_front();
        if (!f.stale) begin
          if (imem_rsp_error) begin
            e = '{32'h0, f.pc, 2'b01};
            m_halt = 1;
          end else begin
            e = '{imem_rsp_data, f.pc, 2'b00};
          end
          m_fifo.push_back(e);
        end
      end
      if (acc) begin
        f = '{m_fetch, 1'b0};
        m_fl.push_back(f);
        m_fetch = m_fetch + 32'd4;
      end
    end
    stray = 0;
  endtask

  localparam logic [31:0] D0 = 32'h0000_0013, D1 = 32'h0010_0093, D2 = 32'h0020_0113;
  localparam logic [31:0] D3 = 32'h0030_0193, D4 = 32'hDEAD_0001, D5 = 32'hDEAD_0002;
  localparam logic [31:0] D6 = 32'h0040_0213, D7 = 32'h1234_5678;
  localparam logic [31:0] P  = 32'h8000_0000;

  vec_t tbl[22];

  initial begin
    logic [31:0] r32;
    logic [31:0] rpc;
    bit          irdy;
    bit          redv;

    // rdy rspv data err irdy redv redpc | reqv addr iv pc fault instr
    tbl[0]  = mk(1, 0, 0,  0, 1, 0, 0,           1, P + 32'h000, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, D0, 0, 1, 0, 0,           1, P + 32'h004, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, D1, 0, 1, 0, 0,           0, P + 32'h008, 1, P + 32'h000, 2'b00, D0);
    tbl[3]  = mk(1, 0, 0,  0, 1, 0, 0,           1, P + 32'h008, 1, P + 32'h004, 2'b00, D1);
    tbl[4]  = mk(0, 1, D2, 0, 1, 0, 0,           1, P + 32'h00C, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0,  0, 0, 0, 0,           1, P + 32'h00C, 1, P + 32'h008, 2'b00, D2);
    tbl[6]  = mk(1, 1, D3, 0, 0, 0, 0,           0, P + 32'h010, 1, P + 32'h008, 2'b00, D2);
    tbl[7]  = mk(1, 0, 0,  0, 1, 0, 0,           0, P + 32'h010, 1, P + 32'h008, 2'b00, D2);
    tbl[8]  = mk(1, 0, 0,  0, 0, 0, 0,           1, P + 32'h010, 1, P + 32'h00C, 2'b00, D3);
    tbl[9]  = mk(1, 0, 0,  0, 1, 0, 0,           0, P + 32'h014, 1, P + 32'h00C, 2'b00, D3);
    tbl[10] = mk(1, 0, 0,  0, 1, 0, 0,           1, P + 32'h014, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, D4, 0, 1, 1, P + 32'h100, 0, P + 32'h018, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, D5, 0, 1, 0, 0,           1, P + 32'h100, 0, 0, 0, 0);
    tbl[13] = mk(0, 1, D6, 0, 1, 0, 0,           1, P + 32'h104, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,  0, 1, 1, P + 32'h102, 0, P + 32'h104, 1, P + 32'h100, 2'b00, D6);
    tbl[15] = mk(1, 0, 0,  0, 1, 0, 0,           0, P + 32'h102, 1, P + 32'h102, 2'b10, 0);
    tbl[16] = mk(1, 0, 0,  0, 1, 0, 0,           0, P + 32'h102, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 0,  0, 1, 1, P + 32'h200, 0, P + 32'h102, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 0,  0, 1, 0, 0,           1, P + 32'h200, 0, 0, 0, 0);
    tbl[19] = mk(0, 1, D7, 1, 1, 0, 0,           1, P + 32'h204, 0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0,  0, 1, 0, 0,           0, P + 32'h204, 1, P + 32'h200, 2'b01, 0);
    tbl[21] = mk(1, 0, 0,  0, 1, 0, 0,           0, P + 32'h204, 0, 0, 0, 0);

    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_error = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, RESET_PC);

    foreach (tbl[i]) begin
      @(negedge clk);
      imem_req_ready = tbl[i].rdy;
      imem_rsp_valid = tbl[i].rspv;
      imem_rsp_data  = tbl[i].data;
      imem_rsp_error = tbl[i].err;
      instr_ready    = tbl[i].irdy;
      redirect_valid = tbl[i].redv;
      redirect_pc    = tbl[i].redpc;
      #1;
      chk($sformatf("t%0d_req_valid", i), imem_req_valid, tbl[i].e_reqv);
      chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_instr_valid", i), instr_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) begin
        chk($sformatf("t%0d_instr_pc", i), instr_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_instr_fault", i), instr_fault, tbl[i].e_fault);
        chk($sformatf("t%0d_instr", i), instr, tbl[i].e_instr);
      end
    end

    // Decoder stalled: only DEPTH words may be requested, then drained in order.
    do_reset();
    ready_pct = 100; rsp_pct = 100; err_pct = 0; err_at = -1;
    n_acc = 0;
    repeat (10) step(0, 0, 0);
    chk("stalled_accepts", n_acc, DEPTH);
    repeat (8) step(1, 0, 0);

    // Two requests in flight when redirecting; both late responses are dropped.
    do_reset();
    rsp_pct = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, P + 32'h100);
    rsp_pct = 100;
    repeat (8) step(1, 0, 0);

    // Access error on the second response halts fetch until a redirect.
    do_reset();
    err_at = 1;
    repeat (8) step(1, 0, 0);
    err_at = -1;
    step(1, 1, P + 32'h300);
    repeat (6) step(1, 0, 0);

    // Random traffic, including misaligned redirects and fetch_pc wrap-around.
    do_reset();
    ready_pct = 80; rsp_pct = 60; err_pct = 3;
    for (int n = 0; n < 3000; n++) begin
      irdy = ($urandom_range(99) < 70);
      redv = ($urandom_range(99) < 5);
      r32  = $urandom;
      case ($urandom_range(15))
        0:       rpc = 32'hFFFF_FFF8;
        1, 2:    rpc = {r32[31:2], 2'($urandom_range(3, 1))};
        default: rpc = {16'h8000, r32[15:2], 2'b00};
      endcase
      step(irdy, redv, rpc);
    end

    // Mid-operation reset, then a stray response with nothing outstanding.
    do_reset();
    ready_pct = 100; rsp_pct = 100; err_pct = 0;
    stray = 1;
    step(1, 0, 0);
    repeat (6) step(1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
